pkt_replay_source: RTL
======================

PKT_REPLAY_SOURCE -- requirements
Module: pkt_replay_source

Interface
REQ-001 Parameter QDR_ADDR_WIDTH, default 19, width of the memory word address and of the tuple count.
REQ-002 Parameter TUPLE_WIDTH, default 144, width of one memory word, which is one tuple.
REQ-003 Parameter FIFO_DEPTH, default 8, output buffer entries; SHALL be a power of 2, at least 2.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 sw_rst  in  1  synchronous software reset, active-high.
REQ-007 start_replay  in  1  level enable for the replay.
REQ-008 mem_high_store  in  QDR_ADDR_WIDTH  number of stored tuples; tuples sit at addresses 0..mem_high_store-1.
REQ-009 mem_rd_req  out  1  read request valid.
REQ-010 mem_rd_addr  out  QDR_ADDR_WIDTH  read address.
REQ-011 mem_rd_gnt  in  1  request accepted when mem_rd_req && mem_rd_gnt.
REQ-012 mem_rd_data_vld  in  1  one read return; returns arrive in request order with any latency of at least 1.
REQ-013 mem_rd_data  in  TUPLE_WIDTH  read return data.
REQ-014 tuple_out_data  out  TUPLE_WIDTH  tuple to the downstream stage.
REQ-015 tuple_out_vld  out  1  tuple valid.
REQ-016 tuple_out_ready  in  1  downstream accepts; a transfer occurs when tuple_out_vld && tuple_out_ready.
REQ-017 replay_busy  out  1  high in the RUN, DRAIN and FLUSH states.
REQ-018 replay_done  out  1  high in the DONE state.
REQ-019 tuple_sent_cnt  out  QDR_ADDR_WIDTH  number of output transfers in the current replay.

Function
REQ-020 FSM states: IDLE, RUN, DRAIN, DONE, FLUSH.
REQ-021 IDLE, start_replay=1: latch mem_high_store into len_q and clear the address and tuple_sent_cnt.
  - len_q!=0: go to RUN.
  - len_q=0: go to DONE.
REQ-022 RUN: mem_rd_req=1 only when start_replay=1 and outstanding+fifo_count < FIFO_DEPTH (credit rule).
  - With start_replay=0, new requests pause; output draining continues.
REQ-023 Accepted request: address+1 and outstanding+1 in the same cycle.
  - Acceptance of address len_q-1: go to DRAIN.
REQ-024 mem_rd_req SHALL NOT drop, and mem_rd_addr SHALL NOT change, while a request is pending without grant.
  - Exception: sw_rst.
REQ-025 mem_rd_data_vld: write mem_rd_data into the FIFO and outstanding-1.
  - Same-cycle accept and return leave outstanding unchanged.
REQ-026 FIFO is first-word-fall-through.
  - tuple_out_vld = FIFO not empty.
  - tuple_out_data = head entry.
  - Simultaneous push and pop are legal at any occupancy.
  - The credit rule guarantees no overflow; overflow is a design error and SHALL be asserted.
REQ-027 Each transfer: tuple_sent_cnt+1, wrapping modulo 2^QDR_ADDR_WIDTH.
REQ-028 Latency: a return in cycle N is visible on tuple_out_vld in cycle N+1 when the FIFO was empty.
REQ-029 DRAIN to DONE in the cycle after outstanding=0, FIFO empty and tuple_sent_cnt=len_q.
REQ-030 DONE holds replay_done=1 and issues no requests; it returns to IDLE when start_replay=0.
REQ-031 sw_rst=1 in any state:
  - Clear the FIFO, the address and tuple_sent_cnt.
  - Deassert mem_rd_req and tuple_out_vld in the next cycle.
  - outstanding!=0: go to FLUSH; otherwise go to IDLE.
REQ-032 FLUSH: discard every return (outstanding-1 each).
  - Go to IDLE in the cycle after outstanding reaches 0.
  - Repeated sw_rst in FLUSH keeps the state in FLUSH.
REQ-033 mem_high_store changes after the latch have no effect until the next IDLE exit.

Reset
REQ-034 resetn=0 asynchronously forces:
  - state IDLE;
  - mem_rd_req=0, mem_rd_addr=0;
  - tuple_out_vld=0, tuple_out_data=0;
  - replay_busy=0, replay_done=0;
  - tuple_sent_cnt=0, outstanding=0, FIFO empty.
REQ-035 Release of resetn SHALL take effect synchronously to clk; the first state change is possible on the second rising edge after release.

Verification
REQ-036 Basic replay.
  - Stimulus: mem_high_store=5, mem_rd_gnt=1, latency 3, tuple_out_ready=1, start_replay held.
  - Required: addresses 0..4 issued once in order; 5 transfers with the memory contents in order; replay_done=1, tuple_sent_cnt=5.
REQ-037 Backpressure with FIFO_DEPTH=8.
  - Stimulus: mem_high_store=20, tuple_out_ready=0.
  - Required: exactly 8 requests issued, then mem_rd_req=0.
  - After ready=1: all 20 tuples delivered, no loss or duplicate.
REQ-038 Grant stalls.
  - Stimulus: mem_rd_gnt toggled randomly.
  - Required: mem_rd_addr held stable while mem_rd_req=1 and gnt=0; final order 0..N-1.
REQ-039 Zero length.
  - Stimulus: mem_high_store=0, start_replay=1.
  - Required: DONE one cycle later; no mem_rd_req; tuple_sent_cnt=0.
REQ-040 sw_rst with reads in flight.
  - Stimulus: sw_rst with 3 reads in flight.
  - Required: FLUSH; 3 returns discarded; tuple_out_vld stays 0; then IDLE.
  - A new start_replay then replays from address 0.
REQ-041 Pause and async reset.
  - start_replay dropped mid-RUN: requests stop and the FIFO drains; reasserted, issue resumes at the next address.
  - resetn asserted mid-RUN: all outputs reach their REQ-034 values without a clock edge.

Source files
------------

// File: rtl/pkt_replay_source_if.sv
// Memory read port and tuple output stream of the packet replay source.
// master = the replay source, slave = memory controller plus downstream stage.
interface pkt_replay_source_if #(
   parameter int QDR_ADDR_WIDTH = 19,
   parameter int TUPLE_WIDTH    = 144
);
   logic                      mem_rd_req;
   logic [QDR_ADDR_WIDTH-1:0] mem_rd_addr;
   logic                      mem_rd_gnt;
   logic                      mem_rd_data_vld;
   logic [TUPLE_WIDTH-1:0]    mem_rd_data;
   logic [TUPLE_WIDTH-1:0]    tuple_out_data;
   logic                      tuple_out_vld;
   logic                      tuple_out_ready;

   modport master (
      output mem_rd_req, mem_rd_addr, tuple_out_data, tuple_out_vld,
      input  mem_rd_gnt, mem_rd_data_vld, mem_rd_data, tuple_out_ready
   );

   modport slave (
      input  mem_rd_req, mem_rd_addr, tuple_out_data, tuple_out_vld,
      output mem_rd_gnt, mem_rd_data_vld, mem_rd_data, tuple_out_ready
   );
endinterface

// File: rtl/pkt_replay_source.sv
// Replays tuples 0..len-1 from QDR memory into a first-word-fall-through
// output FIFO, issuing reads only while in-flight plus buffered data fits.
module pkt_replay_source #(
   parameter int QDR_ADDR_WIDTH = 19,
   parameter int TUPLE_WIDTH    = 144,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      sw_rst,
   input  logic                      start_replay,
   input  logic [QDR_ADDR_WIDTH-1:0] mem_high_store,
   pkt_replay_source_if.master       bus,
   output logic                      replay_busy,
   output logic                      replay_done,
   output logic [QDR_ADDR_WIDTH-1:0] tuple_sent_cnt
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]             DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]             ONE_C   = CW'(1);
   localparam logic [CW-1:0]             ZERO_C  = CW'(0);
   localparam logic [PW-1:0]             ONE_P   = PW'(1);
   localparam logic [QDR_ADDR_WIDTH-1:0] ONE_A   = QDR_ADDR_WIDTH'(1);
   localparam logic [QDR_ADDR_WIDTH-1:0] ZERO_A  = QDR_ADDR_WIDTH'(0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_FLUSH = 3'd4
   } state_t;

   state_t                    state_r, state_nxt_s;
   logic                      rel_r;
   logic [QDR_ADDR_WIDTH-1:0] len_r, len_nxt_s;
   logic [QDR_ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
   logic [QDR_ADDR_WIDTH-1:0] sent_r, sent_nxt_s;
   logic                      req_r, req_nxt_s;
   logic [CW-1:0]             outst_r, outst_nxt_s;
   logic [CW-1:0]             cnt_r, cnt_nxt_s;
   logic [PW-1:0]             wr_ptr_r, wr_nxt_s;
   logic [PW-1:0]             rd_ptr_r, rd_nxt_s;
   logic                      busy_r, done_r;
   logic [TUPLE_WIDTH-1:0]    fifo_mem_r [FIFO_DEPTH];

   logic acc_s, ret_s, vld_s, pop_s, push_s, full_s;

   assign acc_s  = req_r & bus.mem_rd_gnt;
   assign ret_s  = bus.mem_rd_data_vld;
   assign vld_s  = (cnt_r != ZERO_C);
   assign pop_s  = vld_s & bus.tuple_out_ready;
   // Returns are only kept while a replay is active; FLUSH and sw_rst drop them.
   assign push_s = ret_s & ~sw_rst & ((state_r == ST_RUN) | (state_r == ST_DRAIN));
   assign full_s = (cnt_r == DEPTH_C);

   // Next-state, counter, pointer and request computation.
   always_comb begin
      state_nxt_s = state_r;
      len_nxt_s   = len_r;
      outst_nxt_s = outst_r + (acc_s ? ONE_C : ZERO_C) - (ret_s ? ONE_C : ZERO_C);
      cnt_nxt_s   = cnt_r + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
      wr_nxt_s    = push_s ? (wr_ptr_r + ONE_P) : wr_ptr_r;
      rd_nxt_s    = pop_s ? (rd_ptr_r + ONE_P) : rd_ptr_r;
      sent_nxt_s  = pop_s ? (sent_r + ONE_A) : sent_r;
      addr_nxt_s  = acc_s ? (addr_r + ONE_A) : addr_r;
      req_nxt_s   = 1'b0;

      if (sw_rst) begin
         cnt_nxt_s   = ZERO_C;
         wr_nxt_s    = {PW{1'b0}};
         rd_nxt_s    = {PW{1'b0}};
         addr_nxt_s  = ZERO_A;
         sent_nxt_s  = ZERO_A;
         state_nxt_s = (outst_nxt_s != ZERO_C) ? ST_FLUSH : ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_replay) begin
                  len_nxt_s   = mem_high_store;
                  addr_nxt_s  = ZERO_A;
                  sent_nxt_s  = ZERO_A;
                  state_nxt_s = (mem_high_store == ZERO_A) ? ST_DONE : ST_RUN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN:   state_nxt_s = (acc_s && (addr_r == (len_r - ONE_A))) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = ((outst_r == ZERO_C) && (cnt_r == ZERO_C) && (sent_r == len_r))
                                    ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt_s = start_replay ? ST_DONE : ST_IDLE;
            ST_FLUSH: state_nxt_s = (outst_r == ZERO_C) ? ST_IDLE : ST_FLUSH;
            default:  state_nxt_s = ST_IDLE;
         endcase
      end

      // A pending request is held regardless of start_replay or credit.
      if (!sw_rst && (state_nxt_s == ST_RUN)) begin
         req_nxt_s = (req_r && !bus.mem_rd_gnt) ||
                     (start_replay && (addr_nxt_s < len_nxt_s) &&
                      (({1'b0, outst_nxt_s} + {1'b0, cnt_nxt_s}) < {1'b0, DEPTH_C}));
      end else begin
         req_nxt_s = 1'b0;
      end
   end

   // Control registers; rel_r delays the first update to the second edge after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rel_r    <= 1'b0;
         state_r  <= ST_IDLE;
         len_r    <= ZERO_A;
         addr_r   <= ZERO_A;
         sent_r   <= ZERO_A;
         req_r    <= 1'b0;
         outst_r  <= ZERO_C;
         cnt_r    <= ZERO_C;
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else if (!rel_r) begin
         rel_r <= 1'b1;
      end else begin
         state_r  <= state_nxt_s;
         len_r    <= len_nxt_s;
         addr_r   <= addr_nxt_s;
         sent_r   <= sent_nxt_s;
         req_r    <= req_nxt_s;
         outst_r  <= outst_nxt_s;
         cnt_r    <= cnt_nxt_s;
         wr_ptr_r <= wr_nxt_s;
         rd_ptr_r <= rd_nxt_s;
         busy_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_FLUSH);
         done_r   <= (state_nxt_s == ST_DONE);
      end
   end

   // FIFO storage; contents are only observable through the valid-gated head.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= bus.mem_rd_data;
      end
   end

   assign bus.mem_rd_req     = req_r;
   assign bus.mem_rd_addr    = addr_r;
   assign bus.tuple_out_vld  = vld_s;
   assign bus.tuple_out_data = vld_s ? fifo_mem_r[rd_ptr_r] : {TUPLE_WIDTH{1'b0}};
   assign replay_busy        = busy_r;
   assign replay_done        = done_r;
   assign tuple_sent_cnt     = sent_r;

   pkt_replay_source_chk #(
      .QDR_ADDR_WIDTH (QDR_ADDR_WIDTH)
   ) u_chk (
      .clk    (clk),
      .resetn (resetn),
      .sw_rst (sw_rst),
      .push   (push_s),
      .pop    (pop_s),
      .full   (full_s),
      .req    (req_r),
      .gnt    (bus.mem_rd_gnt),
      .addr   (addr_r)
   );
endmodule

// Protocol checker: FIFO never overflows, a pending request is held stable.
module pkt_replay_source_chk #(
   parameter int QDR_ADDR_WIDTH = 19
) (
   input logic                      clk,
   input logic                      resetn,
   input logic                      sw_rst,
   input logic                      push,
   input logic                      pop,
   input logic                      full,
   input logic                      req,
   input logic                      gnt,
   input logic [QDR_ADDR_WIDTH-1:0] addr
);
   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(push && !pop && full));

   a_req_hold: assert property (@(posedge clk) disable iff (!resetn)
      (req && !gnt && !sw_rst) |=> (req && $stable(addr)));
endmodule
